alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_pkg.sv | 33 +++
 rtl/alu_issue_stage_regfile.sv | 39 +++
 rtl/alu_issue_stage.sv | 114 +++++++++++
 tb/tb_alu_issue_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: widths, instruction field positions,
// ALU op selects and the sequencer state encoding.
package alu_issue_pkg;

  localparam int DATA_W  = 4;
  localparam int IDX_W   = 2;
  localparam int OP_W    = 3;
  localparam int INSTR_W = 10;

  // instr = {ld, op[2:0], rd[1:0], rs[1:0], rt[1:0]}
  localparam int LD_BIT = 9;
  localparam int OP_LSB = 6;
  localparam int RD_LSB = 4;
  localparam int RS_LSB = 2;
  localparam int RT_LSB = 0;

  localparam logic [OP_W-1:0] OP_SUB = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD = 3'd1;
  localparam logic [OP_W-1:0] OP_OR  = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_SRA = 3'd4;
  localparam logic [OP_W-1:0] OP_ROL = 3'd5;
  localparam logic [OP_W-1:0] OP_LT  = 3'd6;
  localparam logic [OP_W-1:0] OP_EQ  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// Four 4-bit registers: two combinational read ports, a debug read port and
// one synchronous write port; async active-high reset clears all entries.
module regfile_4x4
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  ra_idx,
  output logic [DATA_W-1:0] ra_data,
  input  logic [IDX_W-1:0]  rb_idx,
  output logic [DATA_W-1:0] rb_data,
  input  logic [IDX_W-1:0]  dbg_idx,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wa_idx,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
    if (we) regs_d[wa_idx] = wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign ra_data  = regs_q[ra_idx];
  assign rb_data  = regs_q[rb_idx];
  assign dbg_data = regs_q[dbg_idx];

endmodule

// File: rtl/alu_issue_stage.sv
// Multi-cycle issue stage: IDLE -> READ -> EXEC -> WB for ALU ops, IDLE -> WB for loads.
// Operands are registered so the external ALU sees stable inputs for all of EXEC.
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  alu_rs,
  output logic [DATA_W-1:0]  alu_rt,
  output logic [OP_W-1:0]    alu_sel,
  input  logic [DATA_W-1:0]  alu_rd,
  output logic               wb_valid,
  output logic [IDX_W-1:0]   wb_idx,
  output logic [DATA_W-1:0]  wb_data,
  input  logic [IDX_W-1:0]   dbg_idx,
  output logic [DATA_W-1:0]  dbg_data
);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [OP_W-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0]   res_q, res_d;

  logic [DATA_W-1:0]   rs_data, rt_data;
  logic                rf_we;
  logic                unused_ld;

  // The load flag only steers the IDLE decision, taken from the live instr.
  assign unused_ld = ir_q[LD_BIT];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sel_d   = sel_q;
    res_d   = res_q;
    rf_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          ir_d = instr;
          if (instr[LD_BIT]) begin
            res_d   = {instr[RS_LSB +: IDX_W], instr[RT_LSB +: IDX_W]};
            state_d = ST_WB;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        opa_d   = rs_data;
        opb_d   = rt_data;
        sel_d   = ir_q[OP_LSB +: OP_W];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = alu_rd;
        state_d = ST_WB;
      end
      ST_WB: begin
        rf_we   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sel_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
    end
  end

  regfile_4x4 u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_idx   (ir_q[RS_LSB +: IDX_W]),
    .ra_data  (rs_data),
    .rb_idx   (ir_q[RT_LSB +: IDX_W]),
    .rb_data  (rt_data),
    .dbg_idx  (dbg_idx),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wa_idx   (ir_q[RD_LSB +: IDX_W]),
    .wd       (res_q)
  );

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_rs      = opa_q;
  assign alu_rt      = opb_q;
  assign alu_sel     = sel_q;
  assign wb_valid    = (state_q == ST_WB);
  assign wb_idx      = ir_q[RD_LSB +: IDX_W];
  assign wb_data     = res_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: external ALU model, architectural register model,
// directed vector table, hand sequences for throughput/reset, then random instructions.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] alu_rs, alu_rt, alu_rd;
  logic [2:0] alu_sel;
  logic       wb_valid;
  logic [1:0] wb_idx;
  logic [3:0] wb_data;
  logic [1:0] dbg_idx;
  logic [3:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] rf [4];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_rs      (alu_rs),
    .alu_rt      (alu_rt),
    .alu_sel     (alu_sel),
    .alu_rd      (alu_rd),
    .wb_valid    (wb_valid),
    .wb_idx      (wb_idx),
    .wb_data     (wb_data),
    .dbg_idx     (dbg_idx),
    .dbg_data    (dbg_data)
  );

  function automatic logic [3:0] alu_fn(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (sel)
      3'd0: r = a - b;
      3'd1: r = a + b;
      3'd2: r = a | b;
      3'd3: r = a & b;
      3'd4: r = {b[3], b[3:1]};
      3'd5: r = {a[2:0], a[3]};
      3'd6: r = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    return r;
  endfunction

  always_comb alu_rd = alu_fn(alu_sel, alu_rs, alu_rt);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_noise(input bit noise);
    instr_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    instr       = 10'($urandom);
  endtask

  // Issue one instruction and follow it to completion against the register model.
  task automatic run_instr(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs, input logic [1:0] rt,
                           input logic [3:0] exp, input bit noise);
    logic [3:0] a, b, old;
    int w;
    a = rf[rs];
    b = rf[rt];
    old = rf[rd];
    w = 0;
    while (!instr_ready && w < 10) begin
      tick();
      w++;
    end
    check("ready_before_issue", 32'(instr_ready), 32'd1);
    instr = {ld, op, rd, rs, rt};
    instr_valid = 1'b1;
    tick();
    drive_noise(noise);
    if (!ld) begin
      check("read_not_ready", 32'(instr_ready), 32'd0);
      check("read_no_wb", 32'(wb_valid), 32'd0);
      tick();
      drive_noise(noise);
      check("exec_alu_rs", 32'(alu_rs), 32'(a));
      check("exec_alu_rt", 32'(alu_rt), 32'(b));
      check("exec_alu_sel", 32'(alu_sel), 32'(op));
      check("exec_no_wb", 32'(wb_valid), 32'd0);
      tick();
    end
    instr_valid = 1'b0;
    dbg_idx = rd;
    #1;
    check("wb_valid", 32'(wb_valid), 32'd1);
    check("wb_idx", 32'(wb_idx), 32'(rd));
    check("wb_data", 32'(wb_data), 32'(exp));
    check("dbg_old_during_wb", 32'(dbg_data), 32'(old));
    tick();
    rf[rd] = exp;
    check("ready_after_wb", 32'(instr_ready), 32'd1);
    check("no_wb_after", 32'(wb_valid), 32'd0);
    check("dbg_new", 32'(dbg_data), 32'(exp));
  endtask

  typedef struct {
    logic       ld;
    logic [2:0] op;
    logic [1:0] rd, rs, rt;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int accepts;
    int accept_at [$];
    logic       r_ld;
    logic [2:0] r_op;
    logic [1:0] r_rd, r_rs, r_rt;
    logic [3:0] r_exp;

    // ld, op, rd, rs, rt, expected wb_data
    vecs[0] = '{1'b1, 3'd0, 2'd1, 2'd1, 2'd1, 4'h5};  // LD r1,5
    vecs[1] = '{1'b1, 3'd0, 2'd2, 2'd0, 2'd3, 4'h3};  // LD r2,3
    vecs[2] = '{1'b0, 3'd1, 2'd3, 2'd1, 2'd2, 4'h8};  // ADD r3=r1+r2
    vecs[3] = '{1'b0, 3'd0, 2'd0, 2'd2, 2'd1, 4'hE};  // SUB r0=r2-r1
    vecs[4] = '{1'b1, 3'd0, 2'd0, 2'd3, 2'd3, 4'hF};  // LD r0,F
    vecs[5] = '{1'b0, 3'd6, 2'd2, 2'd0, 2'd1, 4'h1};  // LT r2=r0<r1 (-1 < 5)
    vecs[6] = '{1'b0, 3'd1, 2'd1, 2'd1, 2'd1, 4'hA};  // ADD r1=r1+r1

    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    dbg_idx = '0;
    for (int i = 0; i < 4; i++) rf[i] = 4'h0;
    tick();
    tick();
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_alu_rs", 32'(alu_rs), 32'd0);
    check("rst_alu_rt", 32'(alu_rt), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dbg_idx = 2'(i);
      #1;
      check("rst_dbg", 32'(dbg_data), 32'd0);
    end
    tick();

    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        tick();
        #1;
      end
      run_instr(vecs[i].ld, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].exp, 1'b0);
    end

    // Back-to-back offers: only every 4th cycle may be taken.
    instr = {1'b0, 3'd1, 2'd0, 2'd1, 2'd2};
    instr_valid = 1'b1;
    accepts = 0;
    for (int c = 0; c < 12; c++) begin
      if (instr_valid && instr_ready) begin
        accepts++;
        accept_at.push_back(c);
      end
      tick();
    end
    instr_valid = 1'b0;
    rf[0] = rf[1] + rf[2];
    check("hold_accepts", 32'(accepts), 32'd3);
    for (int k = 0; k < accept_at.size(); k++)
      check("hold_accept_cycle", 32'(accept_at[k]), 32'(4 * k));
    dbg_idx = 2'd0;
    #1;
    check("hold_result", 32'(dbg_data), 32'(rf[0]));

    // Reset in the middle of EXEC aborts the write.
    run_instr(1'b1, 3'd0, 2'd1, 2'd0, 2'd2, 4'h2, 1'b0);
    run_instr(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 4'h0, 1'b0);
    instr = {1'b0, 3'd1, 2'd3, 2'd1, 2'd1};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("pre_rst_exec_sel", 32'(alu_sel), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 32'(instr_ready), 32'd1);
    check("rst_mid_wb", 32'(wb_valid), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rf[i] = 4'h0;
    for (int c = 0; c < 4; c++) begin
      check("rst_mid_no_wb", 32'(wb_valid), 32'd0);
      tick();
    end
    dbg_idx = 2'd3;
    #1;
    check("rst_mid_r3", 32'(dbg_data), 32'd0);

    // Random instructions with ignored offers while busy.
    for (int n = 0; n < 60; n++) begin
      r_ld = 1'($urandom_range(0, 2) == 0);
      r_op = 3'($urandom);
      r_rd = 2'($urandom);
      r_rs = 2'($urandom);
      r_rt = 2'($urandom);
      r_exp = r_ld ? {r_rs, r_rt} : alu_fn(r_op, rf[r_rs], rf[r_rt]);
      run_instr(r_ld, r_op, r_rd, r_rs, r_rt, r_exp, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_idx = 2'(i);
      #1;
      check("final_regfile", 32'(dbg_data), 32'(rf[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary expected completion");
    $fatal(1, "timeout");
  end

endmodule
